ps2_key_display: RTL and testbench



---
 rtl/ps2_key_display.sv | 153 +++++++++++++++
 tb/tb_ps2_key_display.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ps2_key_display.sv
// PS/2 scan-code decoder and seven-segment display driver.
// Decodes make/break/E0 sequences, tracks the held key and counts distinct presses.
module ps2_key_display #(
  parameter int unsigned CNT_W          = 8,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          HOLD_MODE      = 1'b0,
  parameter bit          CNT_SAT        = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          data_valid_i,
  input  logic [7:0]                    data_i,
  input  logic [7:0]                    asc_code_i,
  output logic [7:0]                    key_code_o,
  output logic                          key_ext_o,
  output logic                          key_down_o,
  output logic                          new_press_o,
  output logic [CNT_W-1:0]              press_cnt_o,
  output logic [(6 + CNT_W/4)*8-1:0]    seg_o
);

  localparam int unsigned NDIG  = 6 + CNT_W / 4;
  localparam int unsigned SEG_W = NDIG * 8;
  localparam int unsigned CDIG  = CNT_W / 4;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_e;

  state_e             state_q, state_d;
  logic [7:0]         key_code_q, key_code_d;
  logic               key_ext_q, key_ext_d;
  logic               key_down_q, key_down_d;
  logic               new_press_q, new_press_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               make_c, rel_c, ext_c, match_c;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hFC;  4'h1: hex7 = 8'h60;  4'h2: hex7 = 8'hDA;  4'h3: hex7 = 8'hF2;
      4'h4: hex7 = 8'h66;  4'h5: hex7 = 8'hB6;  4'h6: hex7 = 8'hBE;  4'h7: hex7 = 8'hE0;
      4'h8: hex7 = 8'hFE;  4'h9: hex7 = 8'hF6;  4'hA: hex7 = 8'hEE;  4'hB: hex7 = 8'h3E;
      4'hC: hex7 = 8'h9C;  4'hD: hex7 = 8'h7A;  4'hE: hex7 = 8'h9E;  default: hex7 = 8'h8E;
    endcase
  endfunction

  // Digit bank in polarity-applied form; key digits blank unless shown.
  function automatic logic [SEG_W-1:0] build_seg(input logic show, input logic [7:0] code,
                                                 input logic [7:0] asc, input logic ext,
                                                 input logic [CNT_W-1:0] cnt);
    logic [SEG_W-1:0] raw;
    raw = '0;
    if (show) begin
      raw[7:0]   = hex7(code[3:0]);
      raw[15:8]  = hex7(code[7:4]);
      raw[23:16] = hex7(asc[3:0]);
      raw[31:24] = hex7(asc[7:4]);
      if (ext) begin
        raw[39:32] = hex7(4'h0);
        raw[47:40] = hex7(4'hE);
      end
    end
    for (int i = 0; i < int'(CDIG); i++) begin
      raw[8*(6+i) +: 8] = hex7(cnt[4*i +: 4]);
    end
    build_seg = SEG_ACTIVE_LOW ? ~raw : raw;
  endfunction

  // Sequence decoder; 00/FF receiver errors never advance the FSM.
  always_comb begin
    state_d = state_q;
    make_c  = 1'b0;
    rel_c   = 1'b0;
    ext_c   = 1'b0;
    if (data_valid_i && data_i != 8'h00 && data_i != 8'hFF) begin
      case (state_q)
        IDLE: begin
          if (data_i == 8'hE0)      state_d = EXT;
          else if (data_i == 8'hF0) state_d = BRK;
          else                      make_c  = 1'b1;
        end
        EXT: begin
          if (data_i == 8'hF0)      state_d = EXT_BRK;
          else if (data_i == 8'hE0) state_d = EXT;
          else begin
            make_c  = 1'b1;
            ext_c   = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          rel_c   = 1'b1;
          state_d = IDLE;
        end
        default: begin
          rel_c   = 1'b1;
          ext_c   = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Key tracking; a make matching the held key is a typematic repeat.
  always_comb begin
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_down_d  = key_down_q;
    cnt_d       = cnt_q;
    new_press_d = 1'b0;
    match_c     = (data_i == key_code_q) && (ext_c == key_ext_q);
    if (make_c && !(key_down_q && match_c)) begin
      key_code_d  = data_i;
      key_ext_d   = ext_c;
      key_down_d  = 1'b1;
      new_press_d = 1'b1;
      if (&cnt_q) cnt_d = CNT_SAT ? cnt_q : '0;
      else        cnt_d = cnt_q + CNT_W'(1);
    end
    if (rel_c && match_c) key_down_d = 1'b0;
  end

  always_comb begin
    seg_d = build_seg(key_down_q | HOLD_MODE, key_code_q, asc_code_i, key_ext_q, cnt_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_down_q  <= 1'b0;
      new_press_q <= 1'b0;
      cnt_q       <= '0;
      seg_q       <= build_seg(1'b0, 8'h00, 8'h00, 1'b0, '0);
    end else begin
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_down_q  <= key_down_d;
      new_press_q <= new_press_d;
      cnt_q       <= cnt_d;
      seg_q       <= seg_d;
    end
  end

  assign key_code_o  = key_code_q;
  assign key_ext_o   = key_ext_q;
  assign key_down_o  = key_down_q;
  assign new_press_o = new_press_q;
  assign press_cnt_o = cnt_q;
  assign seg_o       = seg_q;

endmodule

// File: tb/tb_ps2_key_display.sv
// Directed bench for ps2_key_display: default build plus two CNT_W=4 builds
// (wrapping, and saturating with HOLD_MODE=1) sharing one stimulus stream.
module tb_ps2_key_display;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dv = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [7:0]  asc = 8'h00;

  logic [7:0]  kc_a, kc_b, kc_c;
  logic        ke_a, ke_b, ke_c;
  logic        kd_a, kd_b, kd_c;
  logic        np_a, np_b, np_c;
  logic [7:0]  cnt_a;
  logic [3:0]  cnt_b, cnt_c;
  logic [63:0] seg_a;
  logic [55:0] seg_b, seg_c;

  int n_cmp = 0;
  int n_err = 0;
  int np_seen = 0;

  always #5 clk = ~clk;

  ps2_key_display dut_a (
    .clk_i(clk), .rst_i(rst), .data_valid_i(dv), .data_i(data), .asc_code_i(asc),
    .key_code_o(kc_a), .key_ext_o(ke_a), .key_down_o(kd_a), .new_press_o(np_a),
    .press_cnt_o(cnt_a), .seg_o(seg_a));

  ps2_key_display #(.CNT_W(4), .CNT_SAT(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .data_valid_i(dv), .data_i(data), .asc_code_i(asc),
    .key_code_o(kc_b), .key_ext_o(ke_b), .key_down_o(kd_b), .new_press_o(np_b),
    .press_cnt_o(cnt_b), .seg_o(seg_b));

  ps2_key_display #(.CNT_W(4), .CNT_SAT(1'b1), .HOLD_MODE(1'b1)) dut_c (
    .clk_i(clk), .rst_i(rst), .data_valid_i(dv), .data_i(data), .asc_code_i(asc),
    .key_code_o(kc_c), .key_ext_o(ke_c), .key_down_o(kd_c), .new_press_o(np_c),
    .press_cnt_o(cnt_c), .seg_o(seg_c));

  always @(negedge clk) if (np_a === 1'b1) np_seen++;

  // One byte per edge; consecutive calls give back-to-back strobes.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data = b;
    dv   = 1'b1;
    @(posedge clk);
    #1;
    dv   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data = 8'h1C;
    dv   = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    dv  = 1'b0;
    tick();
    n_cmp++; if (kd_a !== 1'b0) begin n_err++; $display("FAIL reset_key_down: got %b want 0", kd_a); end
    n_cmp++; if (cnt_a !== 8'h00) begin n_err++; $display("FAIL reset_cnt: got %h want 00", cnt_a); end
    n_cmp++; if (kc_a !== 8'h00) begin n_err++; $display("FAIL reset_key_code: got %h want 00", kc_a); end
    n_cmp++; if (seg_a !== 64'h0303_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL reset_seg: got %h want 0303ffffffffffff", seg_a); end
    n_cmp++; if (seg_b !== 56'h03_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL reset_seg_w4: got %h want 03ffffffffffff", seg_b); end
    np_seen = 0;
  endtask

  task automatic test_typematic();
    asc = 8'h61;
    send(8'h1C); send(8'h1C); send(8'h1C);
    tick();
    n_cmp++; if (cnt_a !== 8'h01) begin n_err++; $display("FAIL typ_cnt: got %h want 01", cnt_a); end
    n_cmp++; if (np_seen !== 1) begin n_err++; $display("FAIL typ_pulses: got %0d want 1", np_seen); end
    n_cmp++; if (seg_a !== 64'h039F_FFFF_419F_9F63) begin n_err++; $display("FAIL typ_seg_held: got %h want 039fffff419f9f63", seg_a); end
    send(8'hF0); send(8'h1C);
    n_cmp++; if (kd_a !== 1'b0) begin n_err++; $display("FAIL typ_release: got %b want 0", kd_a); end
    tick();
    n_cmp++; if (seg_a !== 64'h039F_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL typ_seg_blank: got %h want 039fffffffffffff", seg_a); end
  endtask

  task automatic test_extended();
    asc = 8'h00;
    send(8'hE0); send(8'h75);
    n_cmp++; if (ke_a !== 1'b1) begin n_err++; $display("FAIL ext_flag: got %b want 1", ke_a); end
    n_cmp++; if (kc_a !== 8'h75) begin n_err++; $display("FAIL ext_code: got %h want 75", kc_a); end
    n_cmp++; if (cnt_a !== 8'h02) begin n_err++; $display("FAIL ext_cnt: got %h want 02", cnt_a); end
    tick();
    n_cmp++; if (seg_a !== 64'h0325_6103_0303_1F49) begin n_err++; $display("FAIL ext_seg: got %h want 0325610303031f49", seg_a); end
    send(8'hE0); send(8'hF0); send(8'h75);
    n_cmp++; if (kd_a !== 1'b0) begin n_err++; $display("FAIL ext_release: got %b want 0", kd_a); end
  endtask

  task automatic test_rollover();
    send(8'h1C); send(8'h32);
    n_cmp++; if (cnt_a !== 8'h04) begin n_err++; $display("FAIL roll_cnt: got %h want 04", cnt_a); end
    n_cmp++; if (kc_a !== 8'h32) begin n_err++; $display("FAIL roll_code: got %h want 32", kc_a); end
    send(8'hF0); send(8'h1C);
    n_cmp++; if (kd_a !== 1'b1) begin n_err++; $display("FAIL roll_stale_release: got %b want 1", kd_a); end
    send(8'hF0); send(8'h32);
    n_cmp++; if (kd_a !== 1'b0) begin n_err++; $display("FAIL roll_release: got %b want 0", kd_a); end
    n_cmp++; if (np_seen !== 4) begin n_err++; $display("FAIL roll_pulses: got %0d want 4", np_seen); end
  endtask

  task automatic test_error_bytes();
    send(8'hE0); send(8'hFF); send(8'h00); send(8'h75);
    n_cmp++; if (ke_a !== 1'b1 || kc_a !== 8'h75) begin n_err++; $display("FAIL err_ext_make: got %b/%h want 1/75", ke_a, kc_a); end
    n_cmp++; if (cnt_a !== 8'h05) begin n_err++; $display("FAIL err_cnt: got %h want 05", cnt_a); end
    send(8'hF0); send(8'h00); send(8'h75);
    n_cmp++; if (kd_a !== 1'b1) begin n_err++; $display("FAIL err_wrong_ext_release: got %b want 1", kd_a); end
    send(8'hE0); send(8'hF0); send(8'h75);
    n_cmp++; if (kd_a !== 1'b0) begin n_err++; $display("FAIL err_release: got %b want 0", kd_a); end
  endtask

  task automatic test_counter_limit();
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) send(8'h10 + 8'(i));
    n_cmp++; if (cnt_b !== 4'h1) begin n_err++; $display("FAIL cnt_wrap: got %h want 1", cnt_b); end
    n_cmp++; if (cnt_c !== 4'hF) begin n_err++; $display("FAIL cnt_sat: got %h want f", cnt_c); end
    n_cmp++; if (np_c !== 1'b1) begin n_err++; $display("FAIL cnt_sat_pulse: got %b want 1", np_c); end
    n_cmp++; if (cnt_a !== 8'h11) begin n_err++; $display("FAIL cnt_w8: got %h want 11", cnt_a); end
  endtask

  task automatic test_reset_mid_sequence();
    send(8'hE0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(8'h75);
    n_cmp++; if (ke_a !== 1'b0 || kc_a !== 8'h75) begin n_err++; $display("FAIL mid_rst_make: got %b/%h want 0/75", ke_a, kc_a); end
    send(8'hF0); send(8'h75);
    n_cmp++; if (kd_c !== 1'b0) begin n_err++; $display("FAIL mid_rst_release: got %b want 0", kd_c); end
    tick();
    n_cmp++; if (seg_c !== 56'h9F_FFFF_0303_1F49) begin n_err++; $display("FAIL hold_seg: got %h want 9fffff03031f49", seg_c); end
    n_cmp++; if (seg_a[47:0] !== 48'hFFFF_FFFF_FFFF) begin n_err++; $display("FAIL nohold_seg: got %h want ffffffffffff", seg_a[47:0]); end
  endtask

  initial begin
    test_reset();
    test_typematic();
    test_extended();
    test_rollover();
    test_error_bytes();
    test_counter_limit();
    test_reset_mid_sequence();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
